mem_access_unit: RTL and testbench

Memory access sequencer between the multi-cycle control FSM and the single-port block RAM. Converts the controller's single-cycle memory requests (ce/wre/IorDSelector/irWriteEnable) into a registered, latency-aware RAM transaction. Captures read data into the instruction register (source of instOpcode) or the memory data register. Flags overlapping or misaligned requests.

---
 rtl/mem_access_unit_pkg.sv | 23 ++
 rtl/mem_access_unit_latency_counter.sv | 28 ++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory access sequencer.
// State encoding, reset instruction and opcode values.
package mem_access_unit_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE  = 4'b0001;
    localparam state_t S_ISSUE = 4'b0010;
    localparam state_t S_WAIT  = 4'b0100;
    localparam state_t S_DONE  = 4'b1000;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    localparam logic [6:0] OPC_LOAD  = 7'h03;
    localparam logic [6:0] OPC_STORE = 7'h23;
    localparam logic [6:0] OPC_RTYPE = 7'h33;

    // Counter width able to hold MEM_LATENCY-1 (at least one bit).
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mem_access_unit_latency_counter.sv
// Loadable down-counter with zero flag.
// Tracks the remaining RAM read-latency cycles.
module mem_latency_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && !zero) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Memory access sequencer between the control FSM and a single-port RAM.
// Define MEM_ACCESS_CHECK_EN to build overlap/misalignment detection.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int MEM_LATENCY    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      wre,
    input  logic                      IorDSelector,
    input  logic                      irWriteEnable,
    input  logic [ADDR_WIDTH-1:0]     pc,
    input  logic [ADDR_WIDTH-1:0]     aluOut,
    input  logic [DATA_WIDTH-1:0]     writeData,
    input  logic [DATA_WIDTH-1:0]     memDout,
    output logic                      memCe,
    output logic                      memOce,
    output logic                      memWre,
    output logic [MEM_ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0]     memDin,
    output logic [31:0]               instReg,
    output logic [6:0]                instOpcode,
    output logic [DATA_WIDTH-1:0]     mdr,
    output logic                      busy,
    output logic                      accessDone,
    output logic                      accessError
);

    localparam int CW = cnt_width(MEM_LATENCY);
    localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LATENCY - 1);

    state_t                    state;
    state_t                    next_state;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      wre_q;
    logic                      dest_q;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic                      accept;
    logic                      cnt_zero;
    logic [CW-1:0]             cnt;
    logic                      unused_addr_bits;

    assign req_addr = IorDSelector ? aluOut : pc;
    assign accept   = ce && (state == S_IDLE || state == S_DONE);
    assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2],
                                req_addr[1:0], cnt};

    mem_latency_counter #(
        .WIDTH(CW)
    ) u_lat (
        .clk        (clk),
        .rst        (rst),
        .load       (state == S_ISSUE && !wre_q),
        .load_value (LAT_LOAD),
        .dec        (state == S_WAIT),
        .count      (cnt),
        .zero       (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; ce outside IDLE/DONE is ignored.
    always_comb begin
        next_state = S_IDLE;
        unique case (state)
            S_IDLE:  next_state = ce ? S_ISSUE : S_IDLE;
            S_ISSUE: next_state = wre_q ? S_DONE : S_WAIT;
            S_WAIT:  next_state = cnt_zero ? S_DONE : S_WAIT;
            S_DONE:  next_state = ce ? S_ISSUE : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Strobes decoded from state so reset drops them asynchronously.
    always_comb begin
        memCe      = 1'b0;
        memOce     = 1'b0;
        memWre     = 1'b0;
        busy       = 1'b0;
        accessDone = 1'b0;
        unique case (state)
            S_ISSUE: begin
                memCe  = 1'b1;
                memOce = 1'b1;
                memWre = wre_q;
                busy   = 1'b1;
            end
            S_WAIT: begin
                memOce = 1'b1;
                busy   = 1'b1;
            end
            S_DONE:  accessDone = 1'b1;
            default: ;
        endcase
    end

    // Latch the accepted request (word address, data, direction, target).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
            wre_q  <= 1'b0;
            dest_q <= 1'b0;
        end else if (accept) begin
            addr_q <= req_addr[MEM_ADDR_WIDTH+1:2];
            data_q <= writeData;
            wre_q  <= wre;
            dest_q <= irWriteEnable;
        end
    end

    // Capture read data on the edge closing the last WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instReg <= NOP_INST;
            mdr     <= '0;
        end else if (state == S_WAIT && cnt_zero) begin
            if (dest_q) begin
                instReg <= memDout[31:0];
            end else begin
                mdr <= memDout;
            end
        end
    end

    assign memAddr    = addr_q;
    assign memDin     = data_q;
    assign instOpcode = instReg[6:0];

`ifdef MEM_ACCESS_CHECK_EN
    logic err_q;

    // Sticky flag: overlapping request or misaligned address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((ce && busy) || (accept && req_addr[1:0] != 2'b00)) begin
            err_q <= 1'b1;
        end
    end

    assign accessError = err_q;
`else
    assign accessError = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit (latency 1 and 3 instances).
// Reference model derives every output from the documented cycle timing.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        wre = 1'b0;
    logic        sel = 1'b0;
    logic        irw = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] alu = '0;
    logic [31:0] wdata = '0;
    logic [31:0] dout = '0;

    logic        m_ce [2];
    logic        m_oce [2];
    logic        m_wre [2];
    logic [9:0]  m_addr [2];
    logic [31:0] m_din [2];
    logic [31:0] ir [2];
    logic [6:0]  opc [2];
    logic [31:0] mdr [2];
    logic        busy [2];
    logic        done [2];
    logic        err [2];

    int          lat [2] = '{1, 3};
    logic [31:0] exp_ir [2];
    logic [31:0] exp_mdr [2];
    logic        exp_err [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .ce(ce), .wre(wre), .IorDSelector(sel),
        .irWriteEnable(irw), .pc(pc), .aluOut(alu), .writeData(wdata),
        .memDout(dout), .memCe(m_ce[0]), .memOce(m_oce[0]),
        .memWre(m_wre[0]), .memAddr(m_addr[0]), .memDin(m_din[0]),
        .instReg(ir[0]), .instOpcode(opc[0]), .mdr(mdr[0]),
        .busy(busy[0]), .accessDone(done[0]), .accessError(err[0])
    );

    mem_access_unit #(.MEM_LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .ce(ce), .wre(wre), .IorDSelector(sel),
        .irWriteEnable(irw), .pc(pc), .aluOut(alu), .writeData(wdata),
        .memDout(dout), .memCe(m_ce[1]), .memOce(m_oce[1]),
        .memWre(m_wre[1]), .memAddr(m_addr[1]), .memDin(m_din[1]),
        .instReg(ir[1]), .instOpcode(opc[1]), .mdr(mdr[1]),
        .busy(busy[1]), .accessDone(done[1]), .accessError(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every observable of instance i against the model.
    task automatic chk_all(input int i, input string ph, input logic e_ce,
                           input logic e_oce, input logic e_wre,
                           input logic e_busy, input logic e_done,
                           input logic [9:0] e_addr, input logic [31:0] e_din);
        string t;
        t = $sformatf("L%0d_%s", lat[i], ph);
        chk({t, "_memCe"}, 32'(m_ce[i]), 32'(e_ce));
        chk({t, "_memOce"}, 32'(m_oce[i]), 32'(e_oce));
        chk({t, "_memWre"}, 32'(m_wre[i]), 32'(e_wre));
        chk({t, "_busy"}, 32'(busy[i]), 32'(e_busy));
        chk({t, "_done"}, 32'(done[i]), 32'(e_done));
        chk({t, "_memAddr"}, 32'(m_addr[i]), 32'(e_addr));
        chk({t, "_memDin"}, m_din[i], e_din);
        chk({t, "_instReg"}, ir[i], exp_ir[i]);
        chk({t, "_opcode"}, 32'(opc[i]), 32'(exp_ir[i][6:0]));
        chk({t, "_mdr"}, mdr[i], exp_mdr[i]);
        chk({t, "_err"}, 32'(err[i]), 32'(exp_err[i]));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_ir[i]  = 32'h00000013;
            exp_mdr[i] = '0;
            exp_err[i] = 1'b0;
        end
    endtask

    // One request; ovl > 0 re-asserts ce during cycle N+ovl.
    task automatic run_txn(input logic w, input logic s, input logic d,
                           input logic [31:0] p, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int ovl);
        logic [31:0] addr;
        int          last;
        addr = s ? a : p;
        @(negedge clk);
        wre = w; sel = s; irw = d; pc = p; alu = a;
        wdata = wd; dout = rd; ce = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0;
        for (int i = 0; i < 2; i++)
            if (CHK && addr[1:0] != 2'b00) exp_err[i] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            for (int i = 0; i < 2; i++) begin
                last = w ? 2 : 2 + lat[i];
                if (!w && k == last) begin
                    if (d) exp_ir[i] = rd;
                    else exp_mdr[i] = rd;
                end
                chk_all(i, $sformatf("k%0d", k), k == 1,
                        w ? k == 1 : k <= 1 + lat[i], w && k == 1,
                        w ? k == 1 : k <= 1 + lat[i], k == last,
                        addr[11:2], wd);
            end
            @(negedge clk);
            if (ovl == k) ce = 1'b1;
            @(posedge clk); #1;
            if (ovl == k) begin
                ce = 1'b0;
                for (int i = 0; i < 2; i++)
                    if (CHK) exp_err[i] = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        #12;
        for (int i = 0; i < 2; i++)
            chk_all(i, "reset", 0, 0, 0, 0, 0, '0, '0);
        @(negedge clk);
        rst = 1'b0;

        run_txn(0, 0, 1, 32'h8, 32'h0, 32'h0, 32'h00A00093, 0);
        run_txn(0, 1, 0, 32'h0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        run_txn(1, 1, 0, 32'h0, 32'h14, 32'h12345678, 32'h0, 0);

        for (int n = 0; n < 16; n++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    {20'($urandom), 10'($urandom), 2'b00},
                    {20'($urandom), 10'($urandom), 2'b00},
                    $urandom, $urandom, 0);
        end

        run_txn(0, 1, 0, 32'h0, 32'h13, 32'h0, 32'hCAFEF00D, 0);

        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++)
            chk_all(i, "rst2", 0, 0, 0, 0, 0, '0, '0);
        @(negedge clk);
        rst = 1'b0;

        run_txn(0, 1, 0, 32'h0, 32'h20, 32'h0, 32'h0BADF00D, 2);
        run_txn(0, 1, 1, 32'h0, 32'h24, 32'h0, 32'h11111111, 0);

        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b0; irw = 1'b1; wre = 1'b0;
        pc = 32'h40; dout = 32'h00500113; ce = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++)
            chk({$sformatf("L%0d", lat[i]), "_wait_oce"}, 32'(m_oce[i]), 1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++)
            chk_all(i, "rst_wait", 0, 0, 0, 0, 0, '0, '0);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++)
            chk_all(i, "rst_hold", 0, 0, 0, 0, 0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++)
            chk_all(i, "post_rst", 0, 0, 0, 0, 0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
